rx_os_decoder: RTL and testbench
================================

Name: rx_os_decoder

Overview:
- Per-lane receive-side ordered-set decoder; counterpart of the TX ordered-set generator. One instance per lane, after the RX PIPE data interface and before the RX LTSSM.
- Parses the Gen1/Gen2 8b/10b symbol stream, one symbol per clock.
- Recognises TS1, TS2, SKP and EIOS.
- Latches TS fields, counts consecutive identical TSs and flags malformed sets.

Parameters:
- CONSEC_TARGET, 8, number of consecutive identical TSs that sets ts_consec_ok (range 1..15).
- MAX_SKP, 5, maximum SKP symbols accepted after COM.

Ports:
- pclk  input  1  PIPE clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- RxData  input  8  received symbol.
- RxDataK  input  1  1 = K symbol.
- RxValid  input  1  symbol qualifier; the symbol is ignored when low.
- clr_count  input  1  synchronous clear of the stored TS and consecutive count.
- ts_valid  output  1  one-cycle pulse: a well-formed TS has completed.
- os_type  output  2  01 = TS1, 10 = TS2; holds the last completed TS type.
- link_num  output  8  symbol 1 of the last TS.
- lane_num  output  8  symbol 2 of the last TS.
- link_pad  output  1  symbol 1 was PAD.
- lane_pad  output  1  symbol 2 was PAD.
- n_fts  output  8  symbol 3.
- rate_id  output  8  symbol 4.
- train_ctl  output  8  symbol 5.
- consec_cnt  output  4  consecutive identical TS count, saturating at 15.
- ts_consec_ok  output  1  level: consec_cnt >= CONSEC_TARGET.
- skp_det  output  1  pulse: SKP ordered set completed.
- skp_len  output  3  SKP symbol count of the last SKP ordered set.
- eios_det  output  1  pulse: EIOS received.
- os_err  output  1  pulse: malformed ordered set.

Behaviour:
- Symbol encodings:
  - COM = K 0xBC; SKP = K 0x1C; IDL = K 0x7C; PAD = K 0xF7.
  - TS1 ID = D 0x4A; TS2 ID = D 0x45.
- Reset: every output is 0, FSM is in HUNT, stored TS fields and counter are 0.
- RxValid=0 cycles are skipped: state, index and outputs hold, and pulses are not generated.
- FSM states: HUNT, HDR, TSID, SKPS, IDLS.
- HUNT:
  - COM -> HDR, symbol index 1.
  - Any other symbol is discarded with no error.
- After COM (index 1), the next symbol selects the set type:
  - SKP -> SKPS, skp count 1.
  - IDL -> IDLS, IDL count 1.
  - D or PAD -> TS header, capturing link_num.
- HDR (TS header):
  - Index 1: link (D or PAD).
  - Index 2: lane (D or PAD).
  - Index 3..5: D only; values captured into shadow registers.
- TSID (index 6..15):
  - Index 6 fixes the type: 0x4A -> TS1, 0x45 -> TS2, any other -> error.
  - Index 7..15 must equal the index-6 symbol, D.
  - A valid index-15 symbol -> HUNT.
  - The next cycle: ts_valid=1, shadow fields are copied to the outputs and the count is updated. Latency is 1 clock after symbol 15.
- Count update on TS completion:
  - If type and symbols 1..5 equal the stored previous TS, consec_cnt increments, saturating at 15.
  - Otherwise consec_cnt=1 and the new TS becomes the stored one.
- SKPS:
  - Each SKP increments the count.
  - A non-SKP symbol, or reaching MAX_SKP, ends the set: skp_det pulses and skp_len is updated.
  - A non-SKP terminator is then processed as the first symbol in HUNT, so a COM restarts immediately.
  - The count must not exceed MAX_SKP.
- IDLS: a third IDL -> eios_det pulse, then HUNT.
- Any violation inside HDR, TSID or IDLS:
  - os_err pulses, the shadow is discarded and the counter is unchanged.
  - If the offending symbol is COM, re-sync directly to index 1 (no HUNT cycle). Otherwise -> HUNT.
- clr_count:
  - Clears consec_cnt and the stored TS the next cycle.
  - If a TS completes in the same cycle, the clear is applied first, then the TS is counted: consec_cnt=1.
- ts_consec_ok is combinational from consec_cnt.
- Reset mid-OS returns to HUNT and drops the partial set.

Optional Feature:
- Macro: RX_OS_ERRCNT_EN.
- When defined:
  - Adds output err_cnt (8 bits), incremented on each os_err pulse and saturating at 255.
  - err_cnt is cleared by reset or clr_count.
  - If clr_count and an error occur in the same cycle, err_cnt=1.
- When undefined: the port and counter are absent, with no other change.

Test Plan:
- Eight identical TS1s (link 0x00, lane 0x03, n_fts 0xFF, rate 0x02, ctl 0x00) with RxValid=1 -> eight ts_valid pulses, each 1 clk after the last ID. consec_cnt steps 1..8; ts_consec_ok rises on the 8th; os_type=01.
- Four TS1s, then a TS2 with PAD link/lane -> consec_cnt resets to 1, os_type=10, link_pad=lane_pad=1. Twenty more identical TS2s -> consec_cnt saturates at 15.
- COM, SKP, SKP, SKP, COM, then a TS1 -> skp_det pulse with skp_len=3, followed by a correctly decoded TS1 with no os_err. Also COM plus 7 SKPs -> skp_det with skp_len=5.
- COM, IDL, IDL, IDL -> eios_det pulse. COM, IDL, D 0x00 -> os_err, HUNT, no eios_det.
- TS1 with RxValid deasserted for 3 cycles mid-ID -> still decoded, consec_cnt increments. TS1 with ID symbol 9 = 0x45 -> os_err, count unchanged. COM at index 8 -> os_err, and the following TS decodes.
- clr_count asserted on the same cycle as a TS completion while consec_cnt=6 -> consec_cnt=1. Reset asserted mid-TS -> all outputs 0 immediately.

Source files
------------

// File: rtl/rx_os_decoder.sv
// rx_os_decoder
// Per-lane receive ordered-set decoder for the Gen1/Gen2 8b/10b symbol
// stream (one symbol per clock). Recognises TS1, TS2, SKP and EIOS, latches
// the TS fields, counts consecutive identical TSs and flags malformed sets.
//
// Ports:
//   pclk, reset              PIPE clock (rising edge), async active-high reset
//   RxData, RxDataK, RxValid received symbol, K flag, symbol qualifier
//   clr_count                synchronous clear of stored TS and count
//   ts_valid                 pulse one clock after TS symbol 15
//   os_type                  01 = TS1, 10 = TS2 (last completed TS)
//   link_num, lane_num       symbols 1 and 2 of the last TS
//   link_pad, lane_pad       symbol 1 / 2 was PAD
//   n_fts, rate_id, train_ctl symbols 3, 4, 5 of the last TS
//   consec_cnt, ts_consec_ok consecutive identical TS count, count >= target
//   skp_det, skp_len         SKP set completed, its SKP symbol count
//   eios_det, os_err         EIOS received, malformed ordered set
//
// Optional feature: define RX_OS_ERRCNT_EN to add err_cnt, an 8-bit
// saturating count of os_err pulses cleared by reset or clr_count.

module rx_os_decoder #(
    parameter int CONSEC_TARGET = 8,
    parameter int MAX_SKP       = 5
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] RxData,
    input  logic       RxDataK,
    input  logic       RxValid,
    input  logic       clr_count,
    output logic       ts_valid,
    output logic [1:0] os_type,
    output logic [7:0] link_num,
    output logic [7:0] lane_num,
    output logic       link_pad,
    output logic       lane_pad,
    output logic [7:0] n_fts,
    output logic [7:0] rate_id,
    output logic [7:0] train_ctl,
    output logic [3:0] consec_cnt,
    output logic       ts_consec_ok,
    output logic       skp_det,
    output logic [2:0] skp_len,
    output logic       eios_det,
    output logic       os_err
`ifdef RX_OS_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_IDL = 8'h7C;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] TS1_ID  = 8'h4A;
    localparam logic [7:0] TS2_ID  = 8'h45;
    localparam logic [2:0] SKP_LAST = 3'(MAX_SKP - 1);
    localparam logic [3:0] TARGET   = 4'(CONSEC_TARGET);

    typedef enum logic [2:0] {HUNT, HDR, TSID, SKPS, IDLS} state_t;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] cnt_q, cnt_d;

    // Shadow copy of the TS under construction
    logic [7:0] shLink_q, shLane_q, shFts_q, shRate_q, shCtl_q, id_q;
    logic       shLinkPad_q, shLanePad_q;

    // Output registers and the stored-TS valid flag
    logic       tsValid_q, tsValid_d;
    logic [1:0] osType_q, osType_d;
    logic [7:0] link_q, link_d, lane_q, lane_d, fts_q, fts_d;
    logic [7:0] rate_q, rate_d, ctl_q, ctl_d;
    logic       linkPad_q, linkPad_d, lanePad_q, lanePad_d;
    logic [3:0] consec_q, consec_d;
    logic       prevValid_q, prevValid_d;
    logic       skpDet_q, skpDet_d, eiosDet_q, eiosDet_d, osErr_q, osErr_d;
    logic [2:0] skpLen_q, skpLen_d;

    logic       isCom, isSkp, isIdl, isPad, isData;
    logic       tsDone, skpDone, eiosDone, errHit;
    logic [2:0] skpLenNew;
    logic [1:0] newType;
    logic       tsMatch;

    assign isCom  = RxDataK && (RxData == SYM_COM);
    assign isSkp  = RxDataK && (RxData == SYM_SKP);
    assign isIdl  = RxDataK && (RxData == SYM_IDL);
    assign isPad  = RxDataK && (RxData == SYM_PAD);
    assign isData = !RxDataK;

    // State register
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            idx_q   <= 4'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; also raises the per-symbol completion/error events
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tsDone    = 1'b0;
        skpDone   = 1'b0;
        skpLenNew = cnt_q;
        eiosDone  = 1'b0;
        errHit    = 1'b0;
        if (RxValid) begin
            case (state_q)
                HUNT: begin
                    if (isCom) begin
                        state_d = HDR;
                        idx_d   = 4'd1;
                    end
                end
                HDR: begin
                    case (idx_q)
                        4'd1: begin
                            if (isSkp) begin
                                cnt_d = 3'd1;
                                if (MAX_SKP == 1) begin
                                    skpDone   = 1'b1;
                                    skpLenNew = 3'd1;
                                    state_d   = HUNT;
                                end else begin
                                    state_d = SKPS;
                                end
                            end else if (isIdl) begin
                                state_d = IDLS;
                                cnt_d   = 3'd1;
                            end else if (isData || isPad) begin
                                idx_d = 4'd2;
                            end else begin
                                errHit = 1'b1;
                            end
                        end
                        4'd2: begin
                            if (isData || isPad) idx_d = 4'd3;
                            else                 errHit = 1'b1;
                        end
                        default: begin
                            if (!isData) begin
                                errHit = 1'b1;
                            end else if (idx_q == 4'd5) begin
                                state_d = TSID;
                                idx_d   = 4'd6;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                    endcase
                end
                TSID: begin
                    // Index 6 picks the ID; the remaining nine must repeat it
                    if (isData && ((idx_q == 4'd6 && (RxData == TS1_ID || RxData == TS2_ID)) ||
                                   (idx_q != 4'd6 && RxData == id_q))) begin
                        if (idx_q == 4'd15) begin
                            tsDone  = 1'b1;
                            state_d = HUNT;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        errHit = 1'b1;
                    end
                end
                SKPS: begin
                    skpDone = 1'b1;
                    if (isSkp && cnt_q != SKP_LAST) begin
                        skpDone = 1'b0;
                        cnt_d   = cnt_q + 3'd1;
                    end else if (isSkp) begin
                        skpLenNew = cnt_q + 3'd1;
                        state_d   = HUNT;
                    end else if (isCom) begin
                        // The terminator is treated as a fresh HUNT symbol
                        state_d = HDR;
                        idx_d   = 4'd1;
                    end else begin
                        state_d = HUNT;
                    end
                end
                IDLS: begin
                    if (!isIdl) begin
                        errHit = 1'b1;
                    end else if (cnt_q == 3'd2) begin
                        eiosDone = 1'b1;
                        state_d  = HUNT;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
            // A COM inside a broken set starts the next set at once
            if (errHit) begin
                state_d = isCom ? HDR : HUNT;
                idx_d   = 4'd1;
            end
        end
    end

    assign newType = (id_q == TS1_ID) ? 2'b01 : 2'b10;
    assign tsMatch = prevValid_q && (newType == osType_q) &&
                     (shLink_q == link_q) && (shLinkPad_q == linkPad_q) &&
                     (shLane_q == lane_q) && (shLanePad_q == lanePad_q) &&
                     (shFts_q == fts_q) && (shRate_q == rate_q) && (shCtl_q == ctl_q);

    // Output logic; clr_count takes effect before a TS completing alongside it
    always_comb begin
        tsValid_d   = tsDone;
        skpDet_d    = skpDone;
        eiosDet_d   = eiosDone;
        osErr_d     = errHit;
        skpLen_d    = skpDone ? skpLenNew : skpLen_q;
        osType_d    = osType_q;
        link_d      = link_q;
        lane_d      = lane_q;
        linkPad_d   = linkPad_q;
        lanePad_d   = lanePad_q;
        fts_d       = fts_q;
        rate_d      = rate_q;
        ctl_d       = ctl_q;
        consec_d    = consec_q;
        prevValid_d = prevValid_q;
        if (clr_count) begin
            consec_d    = 4'd0;
            prevValid_d = 1'b0;
        end
        if (tsDone) begin
            osType_d    = newType;
            link_d      = shLink_q;
            lane_d      = shLane_q;
            linkPad_d   = shLinkPad_q;
            lanePad_d   = shLanePad_q;
            fts_d       = shFts_q;
            rate_d      = shRate_q;
            ctl_d       = shCtl_q;
            prevValid_d = 1'b1;
            if (tsMatch && !clr_count) consec_d = (consec_q == 4'd15) ? 4'd15 : consec_q + 4'd1;
            else                       consec_d = 4'd1;
        end
    end

    // Shadow capture of TS fields while the set is being received
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            shLink_q    <= 8'd0;
            shLane_q    <= 8'd0;
            shFts_q     <= 8'd0;
            shRate_q    <= 8'd0;
            shCtl_q     <= 8'd0;
            shLinkPad_q <= 1'b0;
            shLanePad_q <= 1'b0;
            id_q        <= 8'd0;
        end else if (RxValid) begin
            if (state_q == HDR) begin
                case (idx_q)
                    4'd1: begin shLink_q <= RxData; shLinkPad_q <= isPad; end
                    4'd2: begin shLane_q <= RxData; shLanePad_q <= isPad; end
                    4'd3: shFts_q  <= RxData;
                    4'd4: shRate_q <= RxData;
                    4'd5: shCtl_q  <= RxData;
                    default: ;
                endcase
            end
            if (state_q == TSID && idx_q == 4'd6) id_q <= RxData;
        end
    end

    // Output registers
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            tsValid_q   <= 1'b0;
            osType_q    <= 2'd0;
            link_q      <= 8'd0;
            lane_q      <= 8'd0;
            linkPad_q   <= 1'b0;
            lanePad_q   <= 1'b0;
            fts_q       <= 8'd0;
            rate_q      <= 8'd0;
            ctl_q       <= 8'd0;
            consec_q    <= 4'd0;
            prevValid_q <= 1'b0;
            skpDet_q    <= 1'b0;
            skpLen_q    <= 3'd0;
            eiosDet_q   <= 1'b0;
            osErr_q     <= 1'b0;
        end else begin
            tsValid_q   <= tsValid_d;
            osType_q    <= osType_d;
            link_q      <= link_d;
            lane_q      <= lane_d;
            linkPad_q   <= linkPad_d;
            lanePad_q   <= lanePad_d;
            fts_q       <= fts_d;
            rate_q      <= rate_d;
            ctl_q       <= ctl_d;
            consec_q    <= consec_d;
            prevValid_q <= prevValid_d;
            skpDet_q    <= skpDet_d;
            skpLen_q    <= skpLen_d;
            eiosDet_q   <= eiosDet_d;
            osErr_q     <= osErr_d;
        end
    end

`ifdef RX_OS_ERRCNT_EN
    logic [7:0] errCnt_q, errCnt_d;

    // Saturating error counter; a clear in the same cycle as an error gives 1
    always_comb begin
        errCnt_d = clr_count ? 8'd0 : errCnt_q;
        if (errHit) errCnt_d = (errCnt_d == 8'hFF) ? 8'hFF : errCnt_d + 8'd1;
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) errCnt_q <= 8'd0;
        else       errCnt_q <= errCnt_d;
    end

    assign err_cnt = errCnt_q;
`endif

    assign ts_valid     = tsValid_q;
    assign os_type      = osType_q;
    assign link_num     = link_q;
    assign lane_num     = lane_q;
    assign link_pad     = linkPad_q;
    assign lane_pad     = lanePad_q;
    assign n_fts        = fts_q;
    assign rate_id      = rate_q;
    assign train_ctl    = ctl_q;
    assign consec_cnt   = consec_q;
    assign ts_consec_ok = (consec_q >= TARGET);
    assign skp_det      = skpDet_q;
    assign skp_len      = skpLen_q;
    assign eios_det     = eiosDet_q;
    assign os_err       = osErr_q;

endmodule

// File: tb/tb_rx_os_decoder.sv
// tb_rx_os_decoder
// Directed bench for rx_os_decoder: TS1/TS2 decode and consecutive counting,
// SKP and EIOS detection, malformed sets, RxValid gaps, clr_count and reset.

module tb_rx_os_decoder;

    logic       pclk;
    logic       reset;
    logic [7:0] RxData;
    logic       RxDataK;
    logic       RxValid;
    logic       clr_count;
    logic       ts_valid;
    logic [1:0] os_type;
    logic [7:0] link_num, lane_num, n_fts, rate_id, train_ctl;
    logic       link_pad, lane_pad;
    logic [3:0] consec_cnt;
    logic       ts_consec_ok;
    logic       skp_det;
    logic [2:0] skp_len;
    logic       eios_det;
    logic       os_err;
`ifdef RX_OS_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [55:0] allOut;
    assign allOut = {ts_valid, os_type, link_num, lane_num, link_pad, lane_pad, n_fts,
                     rate_id, train_ctl, consec_cnt, ts_consec_ok, skp_det, skp_len,
                     eios_det, os_err};

    rx_os_decoder dut (
        .pclk(pclk), .reset(reset), .RxData(RxData), .RxDataK(RxDataK),
        .RxValid(RxValid), .clr_count(clr_count), .ts_valid(ts_valid),
        .os_type(os_type), .link_num(link_num), .lane_num(lane_num),
        .link_pad(link_pad), .lane_pad(lane_pad), .n_fts(n_fts),
        .rate_id(rate_id), .train_ctl(train_ctl), .consec_cnt(consec_cnt),
        .ts_consec_ok(ts_consec_ok), .skp_det(skp_det), .skp_len(skp_len),
        .eios_det(eios_det), .os_err(os_err)
`ifdef RX_OS_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // One symbol presented for exactly one clock; outputs sampled 1 ns after the edge
    task automatic sym(input logic k, input logic [7:0] d, input logic clr);
        @(negedge pclk);
        RxDataK = k; RxData = d; RxValid = 1'b1; clr_count = clr;
        @(posedge pclk);
        #1;
        RxValid = 1'b0; clr_count = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            @(posedge pclk);
            #1;
        end
    endtask

    // TS symbols 1..15; early reports any ts_valid/os_err seen after symbols 1..14
    task automatic sendBody(input logic [7:0] id, input logic linkK, input logic [7:0] link,
                            input logic laneK, input logic [7:0] lane, input logic [7:0] nfts,
                            input logic [7:0] rate, input logic [7:0] ctl, input logic clrLast,
                            input int gapBefore, output logic early);
        early = 1'b0;
        sym(linkK, link, 1'b0); early |= ts_valid | os_err;
        sym(laneK, lane, 1'b0); early |= ts_valid | os_err;
        sym(1'b0, nfts, 1'b0);  early |= ts_valid | os_err;
        sym(1'b0, rate, 1'b0);  early |= ts_valid | os_err;
        sym(1'b0, ctl, 1'b0);   early |= ts_valid | os_err;
        for (int i = 6; i <= 15; i++) begin
            if (i == gapBefore) begin
                idle(3);
                early |= ts_valid | os_err;
            end
            sym(1'b0, id, clrLast && (i == 15));
            if (i != 15) early |= ts_valid | os_err;
        end
    endtask

    task automatic sendStd(input logic clrLast, input int gapBefore, output logic early);
        sym(1'b1, 8'hBC, 1'b0);
        sendBody(8'h4A, 1'b0, 8'h00, 1'b0, 8'h03, 8'hFF, 8'h02, 8'h00, clrLast, gapBefore, early);
    endtask

    task automatic test_reset;
        reset = 1'b1; RxData = 8'h00; RxDataK = 1'b0; RxValid = 1'b0; clr_count = 1'b0;
        idle(3);
        checks++;
        if (allOut !== 56'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h expected 0", allOut);
        end
        @(negedge pclk);
        reset = 1'b0;
        idle(2);
        checks++;
        if (allOut !== 56'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got %h expected 0", allOut);
        end
    endtask

    task automatic test_consec;
        logic early;
        for (int i = 1; i <= 8; i++) begin
            sendStd(1'b0, 0, early);
            checks++;
            if (early !== 1'b0 || ts_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ts1_pulse_%0d early=%b ts_valid=%b expected early=0 ts_valid=1", i, early, ts_valid);
            end
            checks++;
            if (consec_cnt !== 4'(i) || ts_consec_ok !== (i >= 8)) begin
                errors++;
                $display("[TB] FAIL ts1_count_%0d cnt=%0d ok=%b expected cnt=%0d ok=%b", i, consec_cnt, ts_consec_ok, i, (i >= 8));
            end
        end
        checks++;
        if ({os_type, link_num, lane_num, link_pad, lane_pad, n_fts, rate_id, train_ctl} !== {2'b01, 8'h00, 8'h03, 2'b00, 8'hFF, 8'h02, 8'h00}) begin
            errors++;
            $display("[TB] FAIL ts1_fields got type=%b link=%h lane=%h pads=%b%b fts=%h rate=%h ctl=%h expected 01 00 03 00 ff 02 00",
                     os_type, link_num, lane_num, link_pad, lane_pad, n_fts, rate_id, train_ctl);
        end
        idle(1);
        checks++;
        if (ts_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ts_valid_one_cycle got %b expected 0", ts_valid);
        end
    endtask

    task automatic test_ts2_change;
        logic early;
        for (int i = 0; i < 4; i++) sendStd(1'b0, 0, early);
        checks++;
        if (consec_cnt !== 4'd12) begin
            errors++;
            $display("[TB] FAIL ts1_count_12 got %0d expected 12", consec_cnt);
        end
        sym(1'b1, 8'hBC, 1'b0);
        sendBody(8'h45, 1'b1, 8'hF7, 1'b1, 8'hF7, 8'hFF, 8'h02, 8'h00, 1'b0, 0, early);
        checks++;
        if (ts_valid !== 1'b1 || consec_cnt !== 4'd1 || os_type !== 2'b10 || link_pad !== 1'b1 || lane_pad !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ts2_pad got valid=%b cnt=%0d type=%b pads=%b%b expected 1 1 10 11",
                     ts_valid, consec_cnt, os_type, link_pad, lane_pad);
        end
        for (int i = 0; i < 20; i++) begin
            sym(1'b1, 8'hBC, 1'b0);
            sendBody(8'h45, 1'b1, 8'hF7, 1'b1, 8'hF7, 8'hFF, 8'h02, 8'h00, 1'b0, 0, early);
        end
        checks++;
        if (consec_cnt !== 4'd15 || ts_consec_ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ts2_saturate got cnt=%0d ok=%b expected 15 1", consec_cnt, ts_consec_ok);
        end
    endtask

    task automatic test_skp;
        logic early;
        sym(1'b1, 8'hBC, 1'b0);
        sym(1'b1, 8'h1C, 1'b0);
        sym(1'b1, 8'h1C, 1'b0);
        sym(1'b1, 8'h1C, 1'b0);
        checks++;
        if (skp_det !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skp_early got %b expected 0", skp_det);
        end
        sym(1'b1, 8'hBC, 1'b0);
        checks++;
        if (skp_det !== 1'b1 || skp_len !== 3'd3) begin
            errors++;
            $display("[TB] FAIL skp_len3 got det=%b len=%0d expected 1 3", skp_det, skp_len);
        end
        sendBody(8'h4A, 1'b0, 8'h00, 1'b0, 8'h03, 8'hFF, 8'h02, 8'h00, 1'b0, 0, early);
        checks++;
        if (early !== 1'b0 || ts_valid !== 1'b1 || os_err !== 1'b0 || consec_cnt !== 4'd1 || os_type !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ts_after_skp got early=%b valid=%b err=%b cnt=%0d type=%b expected 0 1 0 1 01",
                     early, ts_valid, os_err, consec_cnt, os_type);
        end
        sym(1'b1, 8'hBC, 1'b0);
        for (int i = 1; i <= 5; i++) sym(1'b1, 8'h1C, 1'b0);
        checks++;
        if (skp_det !== 1'b1 || skp_len !== 3'd5) begin
            errors++;
            $display("[TB] FAIL skp_max got det=%b len=%0d expected 1 5", skp_det, skp_len);
        end
        sym(1'b1, 8'h1C, 1'b0);
        sym(1'b1, 8'h1C, 1'b0);
        checks++;
        if (skp_det !== 1'b0 || skp_len !== 3'd5 || os_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skp_excess got det=%b len=%0d err=%b expected 0 5 0", skp_det, skp_len, os_err);
        end
    endtask

    task automatic test_eios;
        logic early;
        sym(1'b1, 8'hBC, 1'b0);
        sym(1'b1, 8'h7C, 1'b0);
        sym(1'b1, 8'h7C, 1'b0);
        sym(1'b1, 8'h7C, 1'b0);
        checks++;
        if (eios_det !== 1'b1 || os_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL eios got det=%b err=%b expected 1 0", eios_det, os_err);
        end
        sym(1'b1, 8'hBC, 1'b0);
        sym(1'b1, 8'h7C, 1'b0);
        sym(1'b0, 8'h00, 1'b0);
        checks++;
        if (os_err !== 1'b1 || eios_det !== 1'b0) begin
            errors++;
            $display("[TB] FAIL eios_bad got err=%b det=%b expected 1 0", os_err, eios_det);
        end
        sendStd(1'b0, 0, early);
        checks++;
        if (ts_valid !== 1'b1 || consec_cnt !== 4'd2) begin
            errors++;
            $display("[TB] FAIL ts_after_eios_err got valid=%b cnt=%0d expected 1 2", ts_valid, consec_cnt);
        end
    endtask

    task automatic test_errors;
        logic early;
        logic seen;
        sendStd(1'b0, 10, early);
        checks++;
        if (early !== 1'b0 || ts_valid !== 1'b1 || consec_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL rxvalid_gap got early=%b valid=%b cnt=%0d expected 0 1 3", early, ts_valid, consec_cnt);
        end
        sym(1'b1, 8'hBC, 1'b0);
        sym(1'b0, 8'h00, 1'b0);
        sym(1'b0, 8'h03, 1'b0);
        sym(1'b0, 8'hFF, 1'b0);
        sym(1'b0, 8'h02, 1'b0);
        sym(1'b0, 8'h00, 1'b0);
        for (int i = 6; i <= 8; i++) sym(1'b0, 8'h4A, 1'b0);
        sym(1'b0, 8'h45, 1'b0);
        checks++;
        if (os_err !== 1'b1 || consec_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL bad_id got err=%b cnt=%0d expected 1 3", os_err, consec_cnt);
        end
        seen = 1'b0;
        for (int i = 10; i <= 15; i++) begin
            sym(1'b0, 8'h4A, 1'b0);
            seen |= ts_valid | os_err;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_id_tail got pulse=%b expected 0", seen);
        end
        sym(1'b1, 8'hBC, 1'b0);
        sym(1'b0, 8'h00, 1'b0);
        sym(1'b0, 8'h03, 1'b0);
        sym(1'b0, 8'hFF, 1'b0);
        sym(1'b0, 8'h02, 1'b0);
        sym(1'b0, 8'h00, 1'b0);
        sym(1'b0, 8'h4A, 1'b0);
        sym(1'b0, 8'h4A, 1'b0);
        sym(1'b1, 8'hBC, 1'b0);
        checks++;
        if (os_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL com_at_idx8 got err=%b expected 1", os_err);
        end
        sendBody(8'h4A, 1'b0, 8'h00, 1'b0, 8'h03, 8'hFF, 8'h02, 8'h00, 1'b0, 0, early);
        checks++;
        if (early !== 1'b0 || ts_valid !== 1'b1 || consec_cnt !== 4'd4) begin
            errors++;
            $display("[TB] FAIL resync_ts got early=%b valid=%b cnt=%0d expected 0 1 4", early, ts_valid, consec_cnt);
        end
`ifdef RX_OS_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd3) begin
            errors++;
            $display("[TB] FAIL err_cnt got %0d expected 3", err_cnt);
        end
`endif
    endtask

    task automatic test_clr;
        logic early;
        sendStd(1'b0, 0, early);
        sendStd(1'b0, 0, early);
        checks++;
        if (consec_cnt !== 4'd6) begin
            errors++;
            $display("[TB] FAIL count_6 got %0d expected 6", consec_cnt);
        end
        sendStd(1'b1, 0, early);
        checks++;
        if (ts_valid !== 1'b1 || consec_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL clr_with_ts got valid=%b cnt=%0d expected 1 1", ts_valid, consec_cnt);
        end
        sendStd(1'b0, 0, early);
        @(negedge pclk);
        clr_count = 1'b1;
        @(posedge pclk);
        #1;
        clr_count = 1'b0;
        checks++;
        if (consec_cnt !== 4'd0 || ts_consec_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_alone got cnt=%0d ok=%b expected 0 0", consec_cnt, ts_consec_ok);
        end
        sendStd(1'b0, 0, early);
        checks++;
        if (consec_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL ts_after_clr got %0d expected 1", consec_cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic early;
        sym(1'b1, 8'hBC, 1'b0);
        sym(1'b0, 8'h00, 1'b0);
        sym(1'b0, 8'h03, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (allOut !== 56'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid got %h expected 0", allOut);
        end
        @(negedge pclk);
        reset = 1'b0;
        sendBody(8'h4A, 1'b0, 8'h00, 1'b0, 8'h03, 8'hFF, 8'h02, 8'h00, 1'b0, 0, early);
        checks++;
        if (ts_valid !== 1'b0 || early !== 1'b0 || consec_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL partial_dropped got valid=%b early=%b cnt=%0d expected 0 0 0", ts_valid, early, consec_cnt);
        end
        sendStd(1'b0, 0, early);
        checks++;
        if (ts_valid !== 1'b1 || consec_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL ts_after_reset got valid=%b cnt=%0d expected 1 1", ts_valid, consec_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_consec;
        test_ts2_change;
        test_skp;
        test_eios;
        test_errors;
        test_clr;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
